// File: rtl/iic_slave.sv
// I2C target: oversampled SCL/SDA front end plus a byte-level transfer FSM
// that bridges device-address / register-address / data framing onto a
// single-cycle register port with auto-increment.
module iic_slave #(
   parameter logic [6:0] SLAVE_ADDR    = 7'h3C,
   parameter int         IIC_ADDR_BYTE = 2,
   parameter int         FILTER_LEN    = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       iic_scl,
   inout  wire                        iic_sda,
   output logic [8*IIC_ADDR_BYTE-1:0] reg_addr,
   output logic                       reg_wr_en,
   output logic [7:0]                 reg_wdata,
   output logic                       reg_rd_en,
   input  logic [7:0]                 reg_rdata,
   output logic                       busy,
   output logic                       nack_seen
);

   localparam int AW = 8*IIC_ADDR_BYTE;
   localparam int CW = $clog2(FILTER_LEN+1);

   typedef enum logic [3:0] {
      IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK,
      WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
   } state_t;

   // bit 0 = SCL, bit 1 = SDA throughout the front end
   logic [1:0]         s1_q, s2_q;
   logic [1:0]         flt_q, flt_d1_q;
   logic [1:0][CW-1:0] cnt_q;

   logic scl_rise, scl_fall, start_p, stop_p, sda_in;

   state_t          state_q;
   logic [2:0]      bit_cnt_q;
   logic [1:0]      byte_cnt_q;
   logic [7:0]      shift_q, tx_q, wdata_q;
   logic [AW-1:0]   acc_q, addr_q;
   logic            wr_en_q, rd_en_q, ld_q, busy_q, nack_q;
   logic            sda_oe_q, ack_ph_q, rw_q, mack_q;
   logic [7:0]      byte_d;
   logic [AW-1:0]   acc_d;

   // Two-flop synchronizer; idle bus level is high on both lines
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= 2'b11;
         s2_q <= 2'b11;
      end else begin
         s1_q <= {iic_sda, iic_scl};
         s2_q <= s1_q;
      end
   end

   // Glitch filter: a new level is accepted after FILTER_LEN consecutive differing samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flt_q <= 2'b11;
         cnt_q <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (s2_q[i] == flt_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CW'(FILTER_LEN-1)) begin
               flt_q[i] <= s2_q[i];
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Previous filtered levels for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) flt_d1_q <= 2'b11;
      else     flt_d1_q <= flt_q;
   end

   assign scl_rise = flt_q[0] & ~flt_d1_q[0];
   assign scl_fall = ~flt_q[0] & flt_d1_q[0];
   // SCL must be high both before and after the SDA edge to count as a bus condition
   assign start_p  = ~flt_q[1] & flt_d1_q[1] & flt_q[0] & flt_d1_q[0];
   assign stop_p   = flt_q[1] & ~flt_d1_q[1] & flt_q[0] & flt_d1_q[0];
   assign sda_in   = flt_q[1];

   assign byte_d = {shift_q[6:0], sda_in};
   assign acc_d  = (acc_q << 8) | AW'(byte_d);

   // Transfer FSM: bits are sampled on SCL rise, slave drive changes after SCL fall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         shift_q    <= '0;
         tx_q       <= '0;
         wdata_q    <= '0;
         acc_q      <= '0;
         addr_q     <= '0;
         wr_en_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         ld_q       <= 1'b0;
         busy_q     <= 1'b0;
         nack_q     <= 1'b0;
         sda_oe_q   <= 1'b0;
         ack_ph_q   <= 1'b0;
         rw_q       <= 1'b0;
         mack_q     <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         rd_en_q <= 1'b0;
         nack_q  <= 1'b0;
         ld_q    <= rd_en_q;
         // auto-increment lands the cycle after the write strobe
         if (wr_en_q) addr_q <= addr_q + 1'b1;
         // read data arrives the cycle after the request; present its MSB right away
         if (ld_q && state_q == RDATA) begin
            tx_q     <= reg_rdata;
            sda_oe_q <= ~reg_rdata[7];
         end
         if (start_p) begin
            state_q   <= DEV_ADDR;
            bit_cnt_q <= '0;
            ack_ph_q  <= 1'b0;
            mack_q    <= 1'b0;
            sda_oe_q  <= 1'b0;
         end else if (stop_p) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            ack_ph_q  <= 1'b0;
            mack_q    <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
         end else begin
            case (state_q)
               DEV_ADDR: if (scl_rise) begin
                  shift_q   <= byte_d;
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 3'd7) begin
                     if (byte_d[7:1] == SLAVE_ADDR) begin
                        state_q  <= DEV_ACK;
                        rw_q     <= byte_d[0];
                        busy_q   <= 1'b1;
                        ack_ph_q <= 1'b0;
                     end else begin
                        state_q <= WAIT_STOP;
                     end
                  end
               end
               // ACK is held low from the fall ending bit 8 to the fall ending the ACK clock
               DEV_ACK, REG_ACK, WDATA_ACK: if (scl_fall) begin
                  if (!ack_ph_q) begin
                     sda_oe_q <= 1'b1;
                     ack_ph_q <= 1'b1;
                  end else begin
                     sda_oe_q <= 1'b0;
                     ack_ph_q <= 1'b0;
                     if (state_q == DEV_ACK) begin
                        if (rw_q) begin
                           state_q   <= RDATA;
                           rd_en_q   <= 1'b1;
                           bit_cnt_q <= '0;
                        end else begin
                           state_q    <= REG_ADDR;
                           byte_cnt_q <= '0;
                        end
                     end else if (state_q == REG_ACK) begin
                        state_q <= (byte_cnt_q == 2'(IIC_ADDR_BYTE)) ? WDATA : REG_ADDR;
                     end else begin
                        state_q <= WDATA;
                     end
                  end
               end
               REG_ADDR: if (scl_rise) begin
                  shift_q   <= byte_d;
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 3'd7) begin
                     acc_q      <= acc_d;
                     byte_cnt_q <= byte_cnt_q + 1'b1;
                     state_q    <= REG_ACK;
                     if (byte_cnt_q == 2'(IIC_ADDR_BYTE-1)) addr_q <= acc_d;
                  end
               end
               WDATA: if (scl_rise) begin
                  shift_q   <= byte_d;
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 3'd7) begin
                     wdata_q <= byte_d;
                     wr_en_q <= 1'b1;
                     state_q <= WDATA_ACK;
                  end
               end
               RDATA: if (scl_fall) begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  tx_q      <= tx_q << 1;
                  if (bit_cnt_q == 3'd7) begin
                     sda_oe_q <= 1'b0;
                     mack_q   <= 1'b0;
                     state_q  <= RDATA_ACK;
                  end else begin
                     sda_oe_q <= ~tx_q[6];
                  end
               end
               RDATA_ACK: begin
                  if (scl_rise) begin
                     if (!sda_in) begin
                        addr_q <= addr_q + 1'b1;
                        mack_q <= 1'b1;
                     end else begin
                        nack_q  <= 1'b1;
                        state_q <= WAIT_STOP;
                     end
                  end else if (scl_fall && mack_q) begin
                     mack_q    <= 1'b0;
                     rd_en_q   <= 1'b1;
                     bit_cnt_q <= '0;
                     state_q   <= RDATA;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign iic_sda   = sda_oe_q ? 1'b0 : 1'bz;
   assign reg_addr  = addr_q;
   assign reg_wr_en = wr_en_q;
   assign reg_wdata = wdata_q;
   assign reg_rd_en = rd_en_q;
   assign busy      = busy_q;
   assign nack_seen = nack_q;

endmodule

// File: tb/tb_iic_slave.sv
// Bench for iic_slave: bit-banged I2C initiator, register-file model and
// table of write transactions plus hand sequences for read/robustness cases.
module tb_iic_slave;

   localparam int H = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        scl_m = 1'b1;
   logic        m_low = 1'b0;
   wire         iic_sda;
   logic [15:0] reg_addr;
   logic        reg_wr_en, reg_rd_en, busy, nack_seen;
   logic [7:0]  reg_wdata;
   logic [7:0]  rdata = 8'h00;

   int n_chk = 0;
   int n_fail = 0;

   int          wr_n = 0, nack_n = 0, low_n = 0, busy_n = 0;
   logic [15:0] wr_a [64];
   logic [7:0]  wr_d [64];

   assign iic_sda = m_low ? 1'b0 : 1'bz;
   pullup (iic_sda);

   always #10 clk = ~clk;

   iic_slave dut (
      .clk(clk), .rst(rst), .iic_scl(scl_m), .iic_sda(iic_sda),
      .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wdata(reg_wdata),
      .reg_rd_en(reg_rd_en), .reg_rdata(rdata), .busy(busy), .nack_seen(nack_seen)
   );

   function automatic logic [7:0] model(input logic [15:0] a);
      case (a)
         16'h300A: return 8'h56;
         16'h300B: return 8'h40;
         16'h300C: return 8'h01;
         default:  return 8'hA5;
      endcase
   endfunction

   // register-file model and bus activity log
   always @(posedge clk) begin
      if (reg_rd_en) rdata <= model(reg_addr);
      if (reg_wr_en && wr_n < 64) begin
         wr_a[wr_n] <= reg_addr;
         wr_d[wr_n] <= reg_wdata;
         wr_n <= wr_n + 1;
      end
      if (nack_seen) nack_n <= nack_n + 1;
      if (!m_low && iic_sda === 1'b0) low_n <= low_n + 1;
      if (busy) busy_n <= busy_n + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      m_low = 1'b0; tick(H);
      scl_m = 1'b1; tick(H);
      m_low = 1'b1; tick(H);
      scl_m = 1'b0; tick(H);
   endtask

   task automatic bus_stop();
      m_low = 1'b1; tick(H);
      scl_m = 1'b1; tick(H);
      m_low = 1'b0; tick(2*H);
   endtask

   // one bit: g inserts a 1-clk SCL pulse during the low phase
   task automatic clk_bit(input logic b, input logic g, output logic s);
      tick(2);
      m_low = ~b;
      if (g) begin
         tick(2); scl_m = 1'b1; tick(1); scl_m = 1'b0; tick(H-5);
      end else begin
         tick(H-2);
      end
      scl_m = 1'b1; tick(H);
      s = iic_sda;  tick(H);
      scl_m = 1'b0; tick(H);
   endtask

   task automatic wr_byte(input logic [7:0] d, input int gbit, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clk_bit(d[i], (i == gbit), s);
      clk_bit(1'b1, 1'b0, s);
      ack = ~s;
   endtask

   task automatic rd_byte(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, 1'b0, s);
         d[i] = s;
      end
      clk_bit(~mack, 1'b0, s);
   endtask

   typedef struct {
      logic [6:0]       dev;
      logic [15:0]      ra;
      int               n;
      logic [2:0][7:0]  d;
      logic             ack;
      int               nwr;
      logic [2:0][15:0] ea;
   } wvec_t;

   function automatic wvec_t mk(input logic [6:0] dev, input logic [15:0] ra, input int n,
                                input logic [7:0] d0, d1, d2, input logic ack, input int nwr,
                                input logic [15:0] a0, a1, a2);
      wvec_t v;
      v.dev = dev; v.ra = ra; v.n = n; v.d = {d2, d1, d0};
      v.ack = ack; v.nwr = nwr; v.ea = {a2, a1, a0};
      return v;
   endfunction

   initial begin
      wvec_t       vt [4];
      logic        ack, got;
      logic [7:0]  b;
      int          bw, bl, bb, bn;

      vt[0] = mk(7'h3C, 16'h3008, 1, 8'h82, 8'h00, 8'h00, 1'b1, 1, 16'h3008, 16'h0000, 16'h0000);
      vt[1] = mk(7'h3C, 16'h30FF, 3, 8'h11, 8'h22, 8'h33, 1'b1, 3, 16'h30FF, 16'h3100, 16'h3101);
      vt[2] = mk(7'h21, 16'h1234, 1, 8'h55, 8'h00, 8'h00, 1'b0, 0, 16'h0000, 16'h0000, 16'h0000);
      vt[3] = mk(7'h3C, 16'hFFFF, 2, 8'hAA, 8'hBB, 8'h00, 1'b1, 2, 16'hFFFF, 16'h0000, 16'h0000);

      // reset state
      tick(5);
      chk("rst_reg_addr", 32'(reg_addr), 32'h0);
      chk("rst_wr_en", 32'(reg_wr_en), 32'h0);
      chk("rst_rd_en", 32'(reg_rd_en), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_nack", 32'(nack_seen), 32'h0);
      chk("rst_sda", 32'(iic_sda), 32'h1);
      rst = 1'b0;
      tick(10);

      // table-driven write transactions
      for (int i = 0; i < 4; i++) begin
         bw = wr_n; bl = low_n; bb = busy_n;
         bus_start();
         wr_byte({vt[i].dev, 1'b0}, -1, ack);
         chk($sformatf("v%0d_dev_ack", i), 32'(ack), 32'(vt[i].ack));
         if (ack) begin
            wr_byte(vt[i].ra[15:8], -1, ack);
            chk($sformatf("v%0d_ra_hi_ack", i), 32'(ack), 32'h1);
            wr_byte(vt[i].ra[7:0], -1, ack);
            chk($sformatf("v%0d_ra_lo_ack", i), 32'(ack), 32'h1);
            for (int j = 0; j < vt[i].n; j++) begin
               wr_byte(vt[i].d[j], -1, ack);
               chk($sformatf("v%0d_d%0d_ack", i, j), 32'(ack), 32'h1);
            end
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'h1);
         end
         bus_stop();
         tick(4);
         chk($sformatf("v%0d_busy_stop", i), 32'(busy), 32'h0);
         chk($sformatf("v%0d_nwr", i), 32'(wr_n - bw), 32'(vt[i].nwr));
         for (int j = 0; j < vt[i].nwr; j++) begin
            chk($sformatf("v%0d_wa%0d", i, j), 32'(wr_a[bw+j]), 32'(vt[i].ea[j]));
            chk($sformatf("v%0d_wd%0d", i, j), 32'(wr_d[bw+j]), 32'(vt[i].d[j]));
         end
         if (!vt[i].ack) begin
            chk($sformatf("v%0d_no_drive", i), 32'(low_n - bl), 32'h0);
            chk($sformatf("v%0d_no_busy", i), 32'(busy_n - bb), 32'h0);
         end
      end

      // combined read: pointer 0x300A, repeated START, three bytes, last NACKed
      bn = nack_n;
      bus_start();
      wr_byte(8'h78, -1, ack); chk("cr_dev_w_ack", 32'(ack), 32'h1);
      wr_byte(8'h30, -1, ack); chk("cr_ra_hi_ack", 32'(ack), 32'h1);
      wr_byte(8'h0A, -1, ack); chk("cr_ra_lo_ack", 32'(ack), 32'h1);
      bus_start();
      wr_byte(8'h79, -1, ack); chk("cr_dev_r_ack", 32'(ack), 32'h1);
      rd_byte(1'b1, b); chk("cr_byte0", 32'(b), 32'h56);
      rd_byte(1'b1, b); chk("cr_byte1", 32'(b), 32'h40);
      rd_byte(1'b0, b); chk("cr_byte2", 32'(b), 32'h01);
      tick(2);
      chk("cr_nack_pulse", 32'(nack_n - bn), 32'h1);
      bus_stop();
      tick(4);
      chk("cr_reg_addr", 32'(reg_addr), 32'h300C);
      chk("cr_busy_stop", 32'(busy), 32'h0);

      // SCL glitch during a data byte
      bw = wr_n;
      bus_start();
      wr_byte(8'h78, -1, ack);
      wr_byte(8'h10, -1, ack);
      wr_byte(8'h00, -1, ack);
      wr_byte(8'h5A, 3, ack); chk("gl_data_ack", 32'(ack), 32'h1);
      bus_stop();
      tick(4);
      chk("gl_nwr", 32'(wr_n - bw), 32'h1);
      chk("gl_addr", 32'(wr_a[bw]), 32'h1000);
      chk("gl_data", 32'(wr_d[bw]), 32'h5A);

      // STOP after four data bits: byte discarded
      bw = wr_n;
      bus_start();
      wr_byte(8'h78, -1, ack);
      wr_byte(8'h20, -1, ack);
      wr_byte(8'h00, -1, ack);
      clk_bit(1'b1, 1'b0, got);
      clk_bit(1'b0, 1'b0, got);
      clk_bit(1'b1, 1'b0, got);
      clk_bit(1'b0, 1'b0, got);
      bus_stop();
      tick(4);
      chk("p4_nwr", 32'(wr_n - bw), 32'h0);
      chk("p4_busy", 32'(busy), 32'h0);

      // reset while the slave drives a '0' read bit
      bus_start();
      wr_byte(8'h78, -1, ack);
      wr_byte(8'h30, -1, ack);
      wr_byte(8'h0C, -1, ack);
      bus_start();
      wr_byte(8'h79, -1, ack);
      m_low = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         tick(1);
         if (iic_sda === 1'b0) got = 1'b1;
      end
      chk("rr_slave_drive", 32'(got), 32'h1);
      rst = 1'b1;
      #1;
      chk("rr_sda_release", 32'(iic_sda), 32'h1);
      scl_m = 1'b1;
      tick(4);
      chk("rr_reg_addr", 32'(reg_addr), 32'h0);
      chk("rr_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      tick(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
